// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
//   Multi-cycle MIPS-subset CPU core. One ALU and one unified memory port are
//   time-shared across FETCH / DECODE / EXEC / MEM / WB. Illegal instructions
//   and misaligned accesses enter a sticky TRAP state.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   mem_req/mem_we   memory request / write enable
//   mem_addr         word-aligned byte address (MEM_ADDR_W bits)
//   mem_wdata        store data
//   mem_rdata        read data, sampled when mem_ready=1
//   mem_ready        transaction completes this cycle
//   pc               current PC register
//   trap             sticky halt indicator
//   instret          retired instruction count (wraps)
//   dbg_sel/dbg_data combinational register-file read, rf[0] reads 0
//   dbg_state        current FSM state (0 FETCH, 1 DECODE, 2 EXEC, 3 MEM,
//                    4 WB, 5 TRAP)
//
// Memory handshake: while mem_req=1 the core holds mem_we, mem_addr and
// mem_wdata constant; the transaction completes in the first cycle where
// mem_ready=1 (rdata sampled on that clock edge). mem_ready is ignored while
// mem_req=0. The core never issues a request from DECODE, so req always drops
// for at least one cycle between a fetch and a data access. A reset in the
// middle of a transaction drops mem_req immediately.

module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int          MEM_ADDR_W       = 16,
  parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           pc,
  output logic                  trap,
  output logic [31:0]           instret,
  input  logic [4:0]            dbg_sel,
  output logic [31:0]           dbg_data,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  logic [2:0]  state;
  logic [31:0] ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};

  // Decode
  logic is_r, is_alu_r, is_jr, is_lw, is_sw, is_beq, is_addi, is_j, is_jal;
  logic legal;
  assign is_r     = (op == OP_RTYPE);
  assign is_alu_r = is_r && (funct == FN_ADD || funct == FN_SUB ||
                             funct == FN_AND || funct == FN_OR  ||
                             funct == FN_SLT);
  assign is_jr    = is_r && (funct == FN_JR);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_addi  = (op == OP_ADDI);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign legal    = is_alu_r || is_jr || is_lw || is_sw || is_beq ||
                    is_addi || is_j || is_jal;

  // Shared ALU: R-type uses B, everything else adds the sign-extended imm.
  logic [31:0] alu_b, alu_result;
  always_comb begin
    alu_b      = is_r ? b : imm_sext;
    alu_result = a + alu_b;
    if (is_r) begin
      case (funct)
        FN_SUB:  alu_result = a - b;
        FN_AND:  alu_result = a & b;
        FN_OR:   alu_result = a | b;
        FN_SLT:  alu_result = {31'd0, ($signed(a) < $signed(b))};
        default: alu_result = a + b;
      endcase
    end
  end

  logic fetch_misalign, data_misalign;
  assign fetch_misalign = TRAP_ON_MISALIGN && (pc[1:0] != 2'b00);
  assign data_misalign  = TRAP_ON_MISALIGN && (alu_result[1:0] != 2'b00);

  // Write-back destination and data
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  assign wb_dest = (is_lw || is_addi) ? rt : rd;
  assign wb_data = is_lw ? mdr : alu_out;

  // Memory port. Low address bits are always forced to 00; with
  // TRAP_ON_MISALIGN=1 a misaligned address never reaches the port anyway.
  logic [31:0] raw_addr;
  assign raw_addr  = (state == S_MEM) ? alu_out : pc;
  assign mem_addr  = {raw_addr[MEM_ADDR_W-1:2], 2'b00};
  assign mem_req   = rst_n && (((state == S_FETCH) && !fetch_misalign) ||
                               (state == S_MEM));
  assign mem_we    = (state == S_MEM) && is_sw;
  assign mem_wdata = b;

  assign trap      = (state == S_TRAP);
  assign dbg_state = state;
  assign dbg_data  = (dbg_sel == 5'd0) ? 32'd0 : rf[dbg_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      instret <= 32'd0;
      ir      <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (fetch_misalign) begin
            state <= S_TRAP;
          end else if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + 32'd4;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a     <= rf[rs];
          b     <= rf[rt];
          state <= legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          if (is_alu_r || is_addi) begin
            alu_out <= alu_result;
            state   <= S_WB;
          end else if (is_lw || is_sw) begin
            if (data_misalign) begin
              state <= S_TRAP;
            end else begin
              alu_out <= alu_result;
              state   <= S_MEM;
            end
          end else begin
            // Control transfers retire straight from EXEC. pc already holds
            // the address of the next sequential instruction.
            if (is_beq && (a == b)) pc <= pc + {imm_sext[29:0], 2'b00};
            if (is_j || is_jal)     pc <= {pc[31:28], ir[25:0], 2'b00};
            if (is_jal)             rf[31] <= pc;
            if (is_jr)              pc <= a;
            instret <= instret + 32'd1;
            state   <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_sw) begin
              instret <= instret + 32'd1;
              state   <= S_FETCH;
            end else begin
              mdr   <= mem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (wb_dest != 5'd0) rf[wb_dest] <= wb_data;
          instret <= instret + 32'd1;
          state   <= S_FETCH;
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core
//   Drives small programs through a bench-side unified memory with
//   configurable wait states, checks architectural state via pc / instret /
//   trap / the debug register port, and checks every store against an
//   expected queue.

module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic [31:0] pc, instret, dbg_data;
  logic        trap;
  logic [4:0]  dbg_sel = 5'd0;
  logic [2:0]  dbg_state;

  mips_multicycle_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .trap      (trap),
    .instret   (instret),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  logic [31:0] mem [256];
  int          wait_n = 0;
  int          wcnt   = 0;
  bit          held   = 1'b0;
  logic [48:0] cap;
  logic [47:0] exp_q[$];

  typedef struct {
    int          scen;
    logic [4:0]  sel;
    logic [31:0] exp;
  } reg_vec_t;
  reg_vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock of the memory model, evaluated on the falling edge. It also
  // checks that request signals hold steady while waiting and compares each
  // completed store against the expected queue.
  task automatic tick();
    logic [47:0] e;
    @(negedge clk);
    if (!mem_req) begin
      wcnt      = 0;
      held      = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));   // must be ignored while idle
      mem_rdata = $urandom;
    end else begin
      if (held) check("req_stable", {15'd0, mem_we, mem_addr, mem_wdata}, {15'd0, cap});
      else begin
        cap  = {mem_we, mem_addr, mem_wdata};
        held = 1'b1;
      end
      if (wcnt >= wait_n) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we) begin
          mem[mem_addr[9:2]] = mem_wdata;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL store_unexpected: got addr %0h data %0h expected no store",
                     mem_addr, mem_wdata);
          end else begin
            e = exp_q.pop_front();
            check("store", {16'd0, mem_addr, mem_wdata}, {16'd0, e});
          end
        end
        wcnt = 0;
        held = 1'b0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wcnt++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  // Release just after a rising edge, then advance to the first falling
  // edge: state shown there is "after 0 edges".
  task automatic release_rst();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic check_regs(input int scen);
    foreach (vecs[i]) begin
      if (vecs[i].scen == scen) begin
        dbg_sel = vecs[i].sel;
        #1;
        check($sformatf("s%0d_r%0d", scen, vecs[i].sel), {32'd0, dbg_data}, {32'd0, vecs[i].exp});
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] r;
    logic [31:0] rsx;
    bit          seen, found;

    r   = 16'($urandom_range(0, 65535));
    rsx = {{16{r[15]}}, r};

    // expected register contents per scenario
    vecs.push_back('{0, 5'd1,  32'd0});
    vecs.push_back('{0, 5'd31, 32'd0});
    vecs.push_back('{1, 5'd1,  32'd5});
    vecs.push_back('{1, 5'd2,  32'hFFFF_FFFD});
    vecs.push_back('{1, 5'd3,  32'd2});
    vecs.push_back('{1, 5'd4,  32'd1});
    vecs.push_back('{1, 5'd5,  32'd8});
    vecs.push_back('{1, 5'd6,  32'd5});
    vecs.push_back('{1, 5'd7,  32'hFFFF_FFFD});
    vecs.push_back('{1, 5'd8,  32'd0});
    vecs.push_back('{2, 5'd1,  32'd5});
    vecs.push_back('{2, 5'd5,  32'd5});
    vecs.push_back('{2, 5'd6,  rsx});
    vecs.push_back('{2, 5'd7,  rsx});
    vecs.push_back('{3, 5'd0,  32'd0});
    vecs.push_back('{3, 5'd31, 32'h14});
    vecs.push_back('{7, 5'd1,  32'd9});

    // ---- reset values ----
    rst_n = 1'b0;
    tick();
    check("rst_pc", {32'd0, pc}, 64'h0);
    check("rst_trap", {63'd0, trap}, 64'd0);
    check("rst_instret", {32'd0, instret}, 64'd0);
    check("rst_req", {63'd0, mem_req}, 64'd0);
    check("rst_state", {61'd0, dbg_state}, 64'd0);
    check_regs(0);

    // ---- scenario 1: ALU program, zero wait states ----
    do_reset();
    wait_n = 0;
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    mem[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
    mem[4] = enc_r(5'd1, 5'd2, 5'd5, 6'h22);
    mem[5] = enc_r(5'd1, 5'd2, 5'd6, 6'h24);
    mem[6] = enc_r(5'd1, 5'd2, 5'd7, 6'h25);
    mem[7] = enc_r(5'd1, 5'd2, 5'd8, 6'h2A);
    mem[8] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    release_rst();
    check("s1_first_req", {63'd0, mem_req}, 64'd1);
    check("s1_first_addr", {48'd0, mem_addr}, 64'd0);
    run(16);
    check("s1_instret16", {32'd0, instret}, 64'd4);
    check("s1_pc16", {32'd0, pc}, 64'h10);
    run(16);
    check("s1_instret32", {32'd0, instret}, 64'd8);
    check_regs(1);
    for (int k = 1; k <= 3; k++) begin
      run(3);
      check($sformatf("s1_loop_pc%0d", k), {32'd0, pc}, 64'h20);
      check($sformatf("s1_loop_instret%0d", k), {32'd0, instret}, 64'd8 + 64'(k));
    end

    // ---- scenario 2: load/store with 3 wait states per transaction ----
    do_reset();
    wait_n = 3;
    mem[0]  = enc_j(6'h02, 26'h10);
    mem[16] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[17] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    mem[18] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
    mem[19] = enc_i(6'h08, 5'd0, 5'd6, r);
    mem[20] = enc_i(6'h2B, 5'd0, 5'd6, 16'd12);
    mem[21] = enc_i(6'h23, 5'd0, 5'd7, 16'd12);
    mem[22] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    exp_q.push_back({16'h0008, 32'd5});
    exp_q.push_back({16'h000C, rsx});
    release_rst();
    run(200);
    check("s2_mem_word2", {32'd0, mem[2]}, 64'd5);
    check("s2_mem_word3", {32'd0, mem[3]}, {32'd0, rsx});
    check("s2_stores_left", 64'(exp_q.size()), 64'd0);
    check("s2_instret_min", {63'd0, (instret >= 32'd7)}, 64'd1);
    check("s2_trap", {63'd0, trap}, 64'd0);
    check_regs(2);

    // ---- scenario 3: $0 writes, jal, jr, beq self-loop ----
    do_reset();
    wait_n = 0;
    for (int i = 0; i < 4; i++) mem[i] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    mem[4]  = enc_j(6'h03, 26'h40);
    mem[5]  = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    mem[64] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
    release_rst();
    run(19);
    check("s3_jal_pc", {32'd0, pc}, 64'h100);
    check("s3_jal_instret", {32'd0, instret}, 64'd5);
    check_regs(3);
    run(3);
    check("s3_jr_pc", {32'd0, pc}, 64'h14);
    check("s3_jr_instret", {32'd0, instret}, 64'd6);
    run(3);
    check("s3_loop_pc", {32'd0, pc}, 64'h14);
    check("s3_loop_instret", {32'd0, instret}, 64'd7);

    // ---- scenario 4: illegal opcode 0x3F ----
    do_reset();
    wait_n = 0;
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    mem[1] = 32'hFC00_0000;
    release_rst();
    run(5);
    check("s4_trap_before", {63'd0, trap}, 64'd0);
    run(1);
    check("s4_trap", {63'd0, trap}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= mem_req;
    end
    check("s4_no_req", {63'd0, seen}, 64'd0);
    check("s4_instret", {32'd0, instret}, 64'd1);
    check("s4_trap_sticky", {63'd0, trap}, 64'd1);

    // ---- scenario 5: misaligned lw from address 2 ----
    do_reset();
    wait_n = 0;
    mem[0] = enc_i(6'h23, 5'd0, 5'd1, 16'd2);
    release_rst();
    run(2);
    check("s5_trap_before", {63'd0, trap}, 64'd0);
    run(1);
    check("s5_trap", {63'd0, trap}, 64'd1);
    check("s5_req", {63'd0, mem_req}, 64'd0);
    check("s5_instret", {32'd0, instret}, 64'd0);

    // ---- scenario 6: unlisted funct under op 0 ----
    do_reset();
    wait_n = 0;
    mem[0] = enc_r(5'd1, 5'd2, 5'd3, 6'h21);
    release_rst();
    run(2);
    check("s6_trap", {63'd0, trap}, 64'd1);

    // ---- scenario 7: reset during a lw MEM wait ----
    do_reset();
    wait_n = 3;
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
    mem[1] = enc_i(6'h23, 5'd0, 5'd2, 16'h20);
    mem[2] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    release_rst();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (mem_req && mem_addr == 16'h20) found = 1'b1;
    end
    check("s7_reached_mem", {63'd0, found}, 64'd1);
    tick();
    check("s7_waiting", {63'd0, mem_req}, 64'd1);
    check_regs(7);
    rst_n = 1'b0;
    #1;
    check("s7_req_drop", {63'd0, mem_req}, 64'd0);
    check("s7_pc", {32'd0, pc}, 64'h0);
    check("s7_instret", {32'd0, instret}, 64'd0);
    check("s7_rf_clear", {32'd0, dbg_data}, 64'd0);
    tick();
    tick();
    release_rst();
    check("s7_refetch_req", {63'd0, mem_req}, 64'd1);
    check("s7_refetch_addr", {48'd0, mem_addr}, 64'd0);
    check("s7_refetch_we", {63'd0, mem_we}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Multi-cycle MIPS-subset processor core. It executes the same instruction subset as the existing single-cycle top, but shares one ALU and one external memory port across 3–5 cycles per instruction. The external memory port uses a req/ready handshake, so instruction fetch and data access tolerate any number of wait states. It adds reset, a sticky trap state for illegal or misaligned accesses, a retired-instruction counter and a debug register-read port. It sits as the CPU core above a unified instruction/data memory.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset; must be word-aligned.
- MEM_ADDR_W, 16, width of the byte address driven on mem_addr; higher PC/address bits are dropped.
- TRAP_ON_MISALIGN, 1, 1 = a fetch or lw/sw address with addr[1:0]≠0 enters TRAP; 0 = low bits are forced to 00.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write; valid while mem_req=1.
- mem_addr  out  MEM_ADDR_W  byte address, word-aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; sampled in the cycle where mem_ready=1.
- mem_ready  in  1  transaction completes in this cycle.
- pc  out  32  current PC register.
- trap  out  1  sticky; core is halted.
- instret  out  32  count of retired instructions; wraps.
- dbg_sel  in  5  register index for debug read.
- dbg_data  out  32  combinational read of rf[dbg_sel]; rf[0] reads 0.

## Operation
- Supported instructions:
  - R-type (op 0) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02, jal 0x03.
- Anything else is illegal and enters TRAP, including an unlisted funct under op 0.
- Arithmetic:
  - All arithmetic is 32-bit modulo; overflow is ignored.
  - slt is a signed compare.
  - Immediates are sign-extended.
- Register rf[0] is hardwired to zero; writes to it are discarded.
- Internal registers: IR, A, B, ALUOut, MDR, PC.
- State machine:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ready: IR←mem_rdata, PC←PC+4 → DECODE. Misaligned PC with TRAP_ON_MISALIGN=1 → TRAP, with no request issued.
  - DECODE: A←rf[rs], B←rf[rt]; decode IR. Illegal → TRAP, else → EXEC.
  - EXEC:
    - R-ALU: ALUOut←A op B → WB.
    - addi: ALUOut←A+sext(imm) → WB.
    - lw/sw: ALUOut←A+sext(imm) → MEM. Misaligned with TRAP_ON_MISALIGN=1 → TRAP.
    - beq: if A==B then PC←PC+(sext(imm)<<2); → FETCH.
    - j: PC←{PC[31:28], imm26, 2'b00} → FETCH.
    - jal: same PC update as j, plus rf[31]←PC (already +4) → FETCH.
    - jr: PC←A → FETCH; no register write.
  - MEM: mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B. On mem_ready: sw → FETCH; lw: MDR←mem_rdata → WB.
  - WB: the register write happens here, then → FETCH.
    - R-type writes rf[rd]←ALUOut.
    - addi writes rf[rt]←ALUOut.
    - lw writes rf[rt]←MDR.
  - TRAP: mem_req=0, trap=1. The state is left only by reset.
- instret increments by 1 on every transition into FETCH from EXEC, MEM or WB. It does not increment on entry to TRAP.

## Timing
- Reset values (asynchronous):
  - State=FETCH, PC=RESET_PC, trap=0, instret=0.
  - All rf entries 0; IR/A/B/ALUOut/MDR=0.
  - mem_req is forced to 0 while rst_n=0.
  - First request is issued in the first cycle after rst_n rises.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable from assertion until the cycle with mem_ready=1 inclusive.
  - mem_ready while mem_req=0 is ignored.
  - mem_req deasserts for at least the DECODE cycle between fetch and data access.
- Cycles per instruction with zero wait states (mem_ready tied 1):
  - beq/j/jal/jr: 3.
  - R-type/addi/sw: 4.
  - lw: 5.
  - Each wait cycle on a transaction adds 1.
- Read-during-write: the WB register write occurs at the end of WB. A following instruction's DECODE therefore sees the new value; no forwarding is needed.
- dbg_data reflects a write from the cycle after the write edge.
- Reset mid-transaction abandons it; the memory side must tolerate req dropping.

## Test plan
- Zero-wait program `addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1`:
  - Required: $3=2, $4=1.
  - Required: instret=4 after 16 cycles.
- Load/store: sw $1,8($0), then lw $5,8($0), with mem_ready low 3 cycles per transaction.
  - Required: mem word 2=5, $5=5.
  - Required: request signals stable throughout each wait.
- Control flow:
  - beq taken with imm=-1 loops to itself: PC stays constant and instret keeps incrementing.
  - jal 0x40 from PC 0x10: PC=0x100, $31=0x14.
  - jr $31: PC=0x14.
- Write to $0: addi $0,$0,7 leaves dbg_sel=0 reading 0.
- Illegal and misaligned accesses:
  - Opcode 0x3F → trap=1 after DECODE, mem_req stays 0, instret frozen.
  - lw from address 0x2 with TRAP_ON_MISALIGN=1 → trap.
- rst_n pulsed low during a lw MEM wait:
  - Required: mem_req drops immediately, PC=RESET_PC, rf cleared.
  - Required: fetch restarts in the cycle after release.
